// File: rtl/vector_divider2_pkg.sv
// Shared definitions for the vector divider: FSM state encoding, the bypass
// classification used for pairs that skip the iterative divider, and the pair stride.
package vector_divider2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RDA,
        RDB,
        LOAD,
        DIV,
        WRQ,
        WRR,
        DONE
    } state_t;

    // Pairs whose result is fixed without dividing: zero divisor, or signed MIN / -1.
    typedef enum logic [1:0] {
        BYP_NONE,
        BYP_DZ,
        BYP_OVF
    } byp_kind_t;

    // Each pair occupies a dividend word followed by a divisor word.
    localparam int PAIR_STRIDE = 2;

endpackage

// File: rtl/seq_divcore.sv
// Unsigned restoring divider: loads magnitudes on start, then produces one
// quotient bit per cycle for NBITS cycles. last flags the final iteration.
module seq_divcore #(
    parameter int NBITS = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [NBITS-1:0] dividend,
    input  logic [NBITS-1:0] divisor,
    output logic [NBITS-1:0] quotient,
    output logic [NBITS-1:0] remainder,
    output logic             last
);

    localparam int CW = $clog2(NBITS + 1);

    logic [NBITS-1:0] q_r, rem_r, d_r;
    logic [CW-1:0]    cnt_r;
    logic [NBITS:0]   shifted;
    logic             fits;
    logic [NBITS-1:0] rem_next;

    // The shifted partial remainder needs one extra bit before the trial subtract.
    always_comb begin
        shifted  = {rem_r, q_r[NBITS-1]};
        fits     = (shifted >= {1'b0, d_r});
        rem_next = fits ? NBITS'(shifted - {1'b0, d_r}) : shifted[NBITS-1:0];
    end

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_r   <= '0;
            rem_r <= '0;
            d_r   <= '0;
            cnt_r <= '0;
        end else if (start) begin
            q_r   <= dividend;
            rem_r <= '0;
            d_r   <= divisor;
            cnt_r <= CW'(NBITS);
        end else if (cnt_r != '0) begin
            q_r   <= {q_r[NBITS-2:0], fits};
            rem_r <= rem_next;
            cnt_r <= cnt_r - CW'(1);
        end
    end

    assign quotient  = q_r;
    assign remainder = rem_r;
    assign last      = (cnt_r == CW'(1));

endmodule

// File: rtl/vector_divider2.sv
// Walks Ndata dividend/divisor pairs in RAM, divides each (signed or unsigned)
// and overwrites the pair with quotient and remainder.
module vector_divider2
    import vector_divider2_pkg::*;
#(
    parameter int RAM_SIZE = 10,
    parameter int NBITS    = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                startvd,
    input  logic                signedvd,
    input  logic [RAM_SIZE-1:0] Base,
    input  logic [RAM_SIZE-1:0] Ndata,
    output logic [RAM_SIZE-1:0] Addr,
    output logic [NBITS-1:0]    Wdata,
    input  logic [NBITS-1:0]    Rdata,
    output logic                Wenable,
    output logic                busyvd,
    output logic                donevd,
    output logic [RAM_SIZE-1:0] dzcount
);

    localparam logic [NBITS-1:0] MOST_NEG = {1'b1, {(NBITS-1){1'b0}}};

    state_t              state_q, state_d;
    byp_kind_t           kind_q, load_kind;
    logic [RAM_SIZE-1:0] ptr_q, ndata_q, idx_q, dz_q;
    logic [RAM_SIZE-1:0] ptr_plus1;
    logic                sgn_q, q_neg_q, r_neg_q, last_pair;
    logic [NBITS-1:0]    a_q, a_mag, b_mag, core_q, core_r, q_word, r_word;
    logic                a_neg, b_neg, core_last;

    // In LOAD, Rdata carries the divisor; a_q holds the dividend captured in RDB.
    assign a_neg     = sgn_q & a_q[NBITS-1];
    assign b_neg     = sgn_q & Rdata[NBITS-1];
    assign a_mag     = a_neg ? -a_q : a_q;
    assign b_mag     = b_neg ? -Rdata : Rdata;
    assign ptr_plus1 = ptr_q + RAM_SIZE'(1);
    assign last_pair = (idx_q == ndata_q - RAM_SIZE'(1));

    seq_divcore #(.NBITS(NBITS)) u_core (
        .clock    (clock),
        .reset    (reset),
        .start    (state_q == LOAD),
        .dividend (a_mag),
        .divisor  (b_mag),
        .quotient (core_q),
        .remainder(core_r),
        .last     (core_last)
    );

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        load_kind = BYP_NONE;
        if (Rdata == '0)
            load_kind = BYP_DZ;
        else if (sgn_q && a_q == MOST_NEG && Rdata == '1)
            load_kind = BYP_OVF;

        case (kind_q)
            BYP_DZ:  begin q_word = '1;       r_word = a_q; end
            BYP_OVF: begin q_word = MOST_NEG; r_word = '0;  end
            default: begin
                q_word = q_neg_q ? -core_q : core_q;
                r_word = r_neg_q ? -core_r : core_r;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        Addr    = '0;
        Wdata   = '0;
        Wenable = 1'b0;
        case (state_q)
            IDLE: if (startvd) state_d = (Ndata == '0) ? DONE : RDA;
            RDA:  begin Addr = ptr_q;     state_d = RDB;  end
            RDB:  begin Addr = ptr_plus1; state_d = LOAD; end
            LOAD: state_d = (load_kind == BYP_NONE) ? DIV : WRQ;
            DIV:  if (core_last) state_d = WRQ;
            WRQ: begin
                Addr    = ptr_q;
                Wdata   = q_word;
                Wenable = 1'b1;
                state_d = WRR;
            end
            WRR: begin
                Addr    = ptr_plus1;
                Wdata   = r_word;
                Wenable = 1'b1;
                state_d = last_pair ? DONE : RDA;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            kind_q  <= BYP_NONE;
            ptr_q   <= '0;
            ndata_q <= '0;
            idx_q   <= '0;
            dz_q    <= '0;
            sgn_q   <= 1'b0;
            a_q     <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (startvd) begin
                    ptr_q   <= Base;
                    ndata_q <= Ndata;
                    sgn_q   <= signedvd;
                    idx_q   <= '0;
                    dz_q    <= '0;
                end
                RDB:  a_q <= Rdata;
                LOAD: begin
                    kind_q  <= load_kind;
                    q_neg_q <= a_neg ^ b_neg;
                    r_neg_q <= a_neg;
                    if (load_kind == BYP_DZ) dz_q <= dz_q + RAM_SIZE'(1);
                end
                WRR: begin
                    ptr_q <= ptr_q + RAM_SIZE'(PAIR_STRIDE);
                    idx_q <= idx_q + RAM_SIZE'(1);
                end
                default: ;
            endcase
        end
    end

    assign busyvd  = (state_q != IDLE) && (state_q != DONE);
    assign donevd  = (state_q == DONE);
    assign dzcount = dz_q;

endmodule

// File: tb/tb_vector_divider2.sv
// Scoreboard bench for vector_divider2: expected RAM writes come from an
// arithmetic reference model and are matched by a monitor on every Wenable cycle.
module tb_vector_divider2;

    localparam int RS = 10;
    localparam int NB = 32;

    typedef struct packed {
        logic [RS-1:0] addr;
        logic [NB-1:0] data;
    } wr_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          startvd, signedvd;
    logic [RS-1:0] Base, Ndata, Addr, dzcount;
    logic [NB-1:0] Wdata, Rdata;
    logic          Wenable, busyvd, donevd;

    logic [NB-1:0] mem [0:(1<<RS)-1];
    logic          tb_we = 1'b0;
    logic [RS-1:0] tb_addr = '0;
    logic [NB-1:0] tb_data = '0;

    wr_t           exp_q[$];
    int            wr_cycles[$];
    int            checks = 0, failures = 0;
    int            cyc = 0, start_cyc = 0, done_seen = 0, exp_dz = 0;
    logic [NB-1:0] pa[8], pb[8];

    vector_divider2 #(.RAM_SIZE(RS), .NBITS(NB)) dut (
        .clock   (clock),
        .reset   (reset),
        .startvd (startvd),
        .signedvd(signedvd),
        .Base    (Base),
        .Ndata   (Ndata),
        .Addr    (Addr),
        .Wdata   (Wdata),
        .Rdata   (Rdata),
        .Wenable (Wenable),
        .busyvd  (busyvd),
        .donevd  (donevd),
        .dzcount (dzcount)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Synchronous RAM: read data appears one clock after the address.
    always @(posedge clock) begin
        if (tb_we) mem[tb_addr] <= tb_data;
        else if (Wenable) mem[Addr] <= Wdata;
        Rdata <= mem[Addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset && donevd) done_seen++;
        if (Wenable) begin
            wr_cycles.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=addr %0h data %0h required=no write", Addr, Wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 64'(Addr), 64'(e.addr));
                check("wr_data", 64'(Wdata), 64'(e.data));
            end
        end
    end

    // Reference: plain 64-bit arithmetic; truncating SV division gives the signed rules.
    function automatic void model(input bit sgn, input logic [NB-1:0] a, input logic [NB-1:0] b,
                                  output logic [NB-1:0] q, output logic [NB-1:0] r, output int dz);
        longint sa, sb;
        dz = 0;
        if (b == '0) begin
            q  = '1;
            r  = a;
            dz = 1;
        end else begin
            sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
            sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
            q  = NB'(sa / sb);
            r  = NB'(sa % sb);
        end
    endfunction

    task automatic poke(input logic [RS-1:0] a, input logic [NB-1:0] d);
        tb_addr = a;
        tb_data = d;
        tb_we   = 1'b1;
        @(negedge clock);
        tb_we   = 1'b0;
    endtask

    task automatic prep(input bit sgn, input logic [RS-1:0] base, input int n);
        logic [NB-1:0] q, r;
        logic [RS-1:0] a;
        int            dz;
        exp_dz = 0;
        for (int k = 0; k < n; k++) begin
            a = base + RS'(2 * k);
            poke(a, pa[k]);
            poke(a + RS'(1), pb[k]);
            model(sgn, pa[k], pb[k], q, r, dz);
            exp_q.push_back('{addr: a, data: q});
            exp_q.push_back('{addr: a + RS'(1), data: r});
            exp_dz += dz;
        end
    endtask

    task automatic run(input bit sgn, input logic [RS-1:0] base, input int n,
                       input bit glitch, output int waited);
        int d0;
        d0 = done_seen;
        wr_cycles.delete();
        signedvd = sgn;
        Base     = base;
        Ndata    = RS'(n);
        startvd  = 1'b1;
        @(negedge clock);
        startvd   = 1'b0;
        start_cyc = cyc;
        Base      = RS'($urandom);
        Ndata     = RS'($urandom);
        signedvd  = ~sgn;
        waited    = 0;
        while (!donevd && waited < 2000) begin
            startvd = glitch && (waited == 4);
            @(negedge clock);
            waited++;
        end
        startvd = 1'b0;
        check("done_reached", 64'(donevd), 64'd1);
        check("busy_in_done", 64'(busyvd), 64'd0);
        @(negedge clock);
        check("done_one_cycle", 64'(donevd), 64'd0);
        check("done_count", 64'(done_seen - d0), 64'd1);
        check("pending_writes", 64'(exp_q.size()), 64'd0);
        check("dzcount", 64'(dzcount), 64'(exp_dz));
        exp_q.delete();
    endtask

    task automatic check_lat(input string name, input int k, input int expl);
        int prev;
        if (wr_cycles.size() < 2 * k + 2) begin
            check(name, 64'(wr_cycles.size()), 64'(2 * k + 2));
        end else begin
            prev = (k == 0) ? start_cyc - 1 : wr_cycles[2 * k - 1];
            check(name, 64'(wr_cycles[2 * k + 1] - prev), 64'(expl));
        end
    endtask

    initial begin
        int            w, n, d0;
        bit            sgn;
        logic [RS-1:0] base;
        logic [NB-1:0] q1, r1, o2a, o2b;

        reset = 1'b0; startvd = 1'b0; signedvd = 1'b0; Base = '0; Ndata = '0;
        #1;
        check("rst_addr",    64'(Addr),    64'd0);
        check("rst_wdata",   64'(Wdata),   64'd0);
        check("rst_wenable", 64'(Wenable), 64'd0);
        check("rst_busy",    64'(busyvd),  64'd0);
        check("rst_done",    64'(donevd),  64'd0);
        check("rst_dz",      64'(dzcount), 64'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Unsigned three-pair run
        pa[0] = 100; pb[0] = 20; pa[1] = 50; pb[1] = 3; pa[2] = 200; pb[2] = 100;
        prep(1'b0, 10'd0, 3);
        run(1'b0, 10'd0, 3, 1'b0, w);
        check("u_m0", 64'(mem[0]), 64'd5);
        check("u_m1", 64'(mem[1]), 64'd0);
        check("u_m2", 64'(mem[2]), 64'd16);
        check("u_m3", 64'(mem[3]), 64'd2);
        check("u_m4", 64'(mem[4]), 64'd2);
        check("u_m5", 64'(mem[5]), 64'd0);
        check_lat("lat_normal0", 0, NB + 5);
        check_lat("lat_normal1", 1, NB + 5);

        // Signed sign rules
        pa[0] = -32'sd7; pb[0] = 32'sd2; pa[1] = 32'sd7; pb[1] = -32'sd2;
        prep(1'b1, 10'd8, 2);
        run(1'b1, 10'd8, 2, 1'b0, w);
        check("s_m8",  64'(mem[8]),  64'hFFFF_FFFD);
        check("s_m9",  64'(mem[9]),  64'hFFFF_FFFF);
        check("s_m10", 64'(mem[10]), 64'hFFFF_FFFD);
        check("s_m11", 64'(mem[11]), 64'h1);

        // Divide by zero and signed overflow bypass
        pa[0] = 9; pb[0] = 0;
        prep(1'b0, 10'd20, 1);
        run(1'b0, 10'd20, 1, 1'b0, w);
        check("dz_q", 64'(mem[20]), 64'hFFFF_FFFF);
        check("dz_r", 64'(mem[21]), 64'd9);
        check("dz_cnt", 64'(dzcount), 64'd1);
        check_lat("lat_dz", 0, 5);
        pa[0] = 32'h8000_0000; pb[0] = 32'hFFFF_FFFF; pa[1] = -32'sd100; pb[1] = 32'sd7;
        prep(1'b1, 10'd30, 2);
        run(1'b1, 10'd30, 2, 1'b0, w);
        check("ovf_q", 64'(mem[30]), 64'h8000_0000);
        check("ovf_r", 64'(mem[31]), 64'd0);
        check_lat("lat_ovf", 0, 5);
        check_lat("lat_after_ovf", 1, NB + 5);

        // Address wrap
        pa[0] = $urandom; pb[0] = $urandom_range(1, 5000);
        pa[1] = $urandom; pb[1] = $urandom_range(1, 70000);
        prep(1'b0, 10'd1022, 2);
        run(1'b0, 10'd1022, 2, 1'b0, w);
        check("wrap_q0", 64'(mem[0]), 64'(pa[1] / pb[1]));
        check("wrap_r1", 64'(mem[1]), 64'(pa[1] % pb[1]));

        // Empty run after a run that left dzcount nonzero
        pa[0] = 5; pb[0] = 0;
        prep(1'b0, 10'd50, 1);
        run(1'b0, 10'd50, 1, 1'b0, w);
        prep(1'b0, 10'd100, 0);
        run(1'b0, 10'd100, 0, 1'b0, w);
        check("n0_latency", 64'(w), 64'd0);
        check("n0_writes", 64'(wr_cycles.size()), 64'd0);

        // Start pulse during busy must be ignored
        pa[0] = $urandom; pb[0] = $urandom_range(1, 99);
        pa[1] = $urandom; pb[1] = 0;
        prep(1'b0, 10'd200, 2);
        run(1'b0, 10'd200, 2, 1'b1, w);

        // Randomised runs
        for (int t = 0; t < 8; t++) begin
            sgn  = 1'($urandom);
            base = RS'($urandom);
            n    = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                pa[k] = ($urandom_range(0, 2) == 0) ? NB'($urandom_range(0, 300)) : NB'($urandom);
                pb[k] = ($urandom_range(0, 2) == 0) ? NB'($urandom_range(0, 20)) : NB'($urandom >> $urandom_range(0, 31));
                if (sgn && $urandom_range(0, 1) == 1) pb[k] = -pb[k];
                if ($urandom_range(0, 5) == 0) pb[k] = '0;
                if (sgn && $urandom_range(0, 7) == 0) begin
                    pa[k] = 32'h8000_0000;
                    pb[k] = 32'hFFFF_FFFF;
                end
            end
            prep(sgn, base, n);
            run(sgn, base, n, 1'b0, w);
        end

        // Reset during the divide of the second pair
        pa[0] = $urandom; pb[0] = $urandom_range(1, 1000);
        pa[1] = $urandom; pb[1] = $urandom_range(1, 1000);
        model(1'b0, pa[0], pb[0], q1, r1, n);
        o2a = pa[1]; o2b = pb[1];
        prep(1'b0, 10'd40, 2);
        wr_cycles.delete();
        d0 = done_seen;
        signedvd = 1'b0; Base = 10'd40; Ndata = 10'd2; startvd = 1'b1;
        @(negedge clock);
        startvd = 1'b0;
        w = 0;
        while (wr_cycles.size() < 2 && w < 200) begin
            @(negedge clock);
            w++;
        end
        check("pair1_written", 64'(wr_cycles.size()), 64'd2);
        repeat (8) @(negedge clock);
        check("busy_before_rst", 64'(busyvd), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_addr",    64'(Addr),    64'd0);
        check("mid_rst_wdata",   64'(Wdata),   64'd0);
        check("mid_rst_wenable", 64'(Wenable), 64'd0);
        check("mid_rst_busy",    64'(busyvd),  64'd0);
        check("mid_rst_done",    64'(donevd),  64'd0);
        exp_q.delete();
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (NB + 20) @(negedge clock);
        check("no_done_after_rst", 64'(done_seen - d0), 64'd0);
        check("rst_p1_q", 64'(mem[40]), 64'(q1));
        check("rst_p1_r", 64'(mem[41]), 64'(r1));
        check("rst_p2_a", 64'(mem[42]), 64'(o2a));
        check("rst_p2_b", 64'(mem[43]), 64'(o2b));
        check("rst_dz_after", 64'(dzcount), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
